// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: fetch hold encodings and FSM states.
package pipe_ctrl_pkg;

  localparam logic [1:0] HOLD_NONE = 2'd0;
  localparam logic [1:0] HOLD_PC   = 2'd1;
  localparam logic [1:0] HOLD_PPL  = 2'd2;

  typedef enum logic [1:0] {
    CTRL_RUN     = 2'd0,
    CTRL_BR_WAIT = 2'd1,
    CTRL_DRAIN   = 2'd2,
    CTRL_ENTER   = 2'd3
  } ctrl_state_e;

  // The drain counter loads cycles-1 so that a count of N holds fetch for exactly N cycles.
  function automatic logic [2:0] drain_init(input int cyc);
    return 3'(cyc - 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: holds fetch across branches, redirects on EX resolution,
// stalls on load-use hazards and sequences interrupt entry and RETI return.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(16'h0004),
  parameter int                DRAIN_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_pc,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              ex_br_done,
  input  logic              ex_jump_flag,
  input  logic [ADDR_W-1:0] ex_jump_pc,
  input  logic              ex_reti,
  input  logic              ld_hazard,
  input  logic              int_req,
  input  logic              int_en,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_pc,
  output logic [1:0]        hold_flag,
  output logic              int_ack,
  output logic              in_isr,
  output logic [ADDR_W-1:0] epc
);

  localparam logic [2:0] DRAIN_INIT = drain_init(DRAIN_CYC);

  ctrl_state_e state;
  logic [2:0]  drain_cnt;

  // Redirect and hold must reach fetch in the same cycle EX resolves, so they are combinational.
  always_comb begin
    jump_flag = 1'b0;
    jump_pc   = '0;
    hold_flag = HOLD_NONE;
    case (state)
      CTRL_RUN: begin
        hold_flag = ld_hazard ? HOLD_PPL : HOLD_NONE;
      end
      CTRL_BR_WAIT: begin
        hold_flag = ld_hazard ? HOLD_PPL : HOLD_PC;
        if (ex_br_done) begin
          if (ex_reti) begin
            jump_flag = 1'b1;
            jump_pc   = epc;
          end else if (ex_jump_flag) begin
            jump_flag = 1'b1;
            jump_pc   = ex_jump_pc;
          end
        end
      end
      CTRL_DRAIN: begin
        hold_flag = ld_hazard ? HOLD_PPL : HOLD_PC;
      end
      CTRL_ENTER: begin
        jump_flag = 1'b1;
        jump_pc   = INT_VECTOR;
      end
      default: ;
    endcase
  end

  // A pending branch beats a same-cycle interrupt; the request is simply re-sampled back in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CTRL_RUN;
      drain_cnt <= 3'd0;
      in_isr    <= 1'b0;
      epc       <= '0;
      int_ack   <= 1'b0;
    end else begin
      int_ack <= 1'b0;
      case (state)
        CTRL_RUN: begin
          if (int_req && int_en && !in_isr && !hold_pc) begin
            state     <= CTRL_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end else if (hold_pc) begin
            state <= CTRL_BR_WAIT;
          end
        end
        CTRL_BR_WAIT: begin
          if (ex_br_done) begin
            if (ex_reti) in_isr <= 1'b0;
            state <= CTRL_RUN;
          end
        end
        CTRL_DRAIN: begin
          if (!ld_hazard) begin
            if (drain_cnt == 3'd0) state <= CTRL_ENTER;
            else drain_cnt <= drain_cnt - 3'd1;
          end
        end
        CTRL_ENTER: begin
          epc     <= inst_addr;
          in_isr  <= 1'b1;
          int_ack <= 1'b1;
          state   <= CTRL_RUN;
        end
        default: state <= CTRL_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: each step pushes its expected outputs and
// the sample at the falling edge pops and compares them.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold_pc, ex_br_done, ex_jump_flag, ex_reti, ld_hazard, int_req, int_en;
  logic [15:0] inst_addr, ex_jump_pc;
  logic        jump_flag, int_ack, in_isr;
  logic [15:0] jump_pc, epc;
  logic [1:0]  hold_flag;

  typedef struct {
    string       tag;
    logic [1:0]  hold;
    logic        jf;
    logic [15:0] jpc;
    logic        ack;
    logic        isr;
    logic [15:0] epc;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  pipe_ctrl #(.ADDR_W(16), .INT_VECTOR(16'h0004), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .hold_pc(hold_pc), .inst_addr(inst_addr),
    .ex_br_done(ex_br_done), .ex_jump_flag(ex_jump_flag), .ex_jump_pc(ex_jump_pc),
    .ex_reti(ex_reti), .ld_hazard(ld_hazard), .int_req(int_req), .int_en(int_en),
    .jump_flag(jump_flag), .jump_pc(jump_pc), .hold_flag(hold_flag),
    .int_ack(int_ack), .in_isr(in_isr), .epc(epc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic hp, input logic bd, input logic ejf, input logic [15:0] ejpc,
                               input logic rt, input logic ld, input logic rq, input logic en,
                               input logic [15:0] ia);
    @(posedge clk);
    #1;
    hold_pc = hp; ex_br_done = bd; ex_jump_flag = ejf; ex_jump_pc = ejpc;
    ex_reti = rt; ld_hazard = ld; int_req = rq; int_en = en; inst_addr = ia;
  endtask

  task automatic expectOut(input string tag, input logic [1:0] hold, input logic jf, input logic [15:0] jpc,
                           input logic ack, input logic isr, input logic [15:0] e);
    exp_t x;
    x.tag = tag; x.hold = hold; x.jf = jf; x.jpc = jpc; x.ack = ack; x.isr = isr; x.epc = e;
    sb.push_back(x);
  endtask

  task automatic cmp(input string tag, input string field, input logic [15:0] obs, input logic [15:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s.%s: observed %h expected %h", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput(input bit wait_edge);
    exp_t x;
    if (wait_edge) @(negedge clk);
    tests_run++;
    assert (sb.size() > 0) else begin
      tests_failed++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      cmp(x.tag, "hold_flag", {14'd0, hold_flag}, {14'd0, x.hold});
      cmp(x.tag, "jump_flag", {15'd0, jump_flag}, {15'd0, x.jf});
      cmp(x.tag, "jump_pc",   jump_pc, x.jpc);
      cmp(x.tag, "int_ack",   {15'd0, int_ack}, {15'd0, x.ack});
      cmp(x.tag, "in_isr",    {15'd0, in_isr}, {15'd0, x.isr});
      cmp(x.tag, "epc",       epc, x.epc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hold_pc = 0; ex_br_done = 0; ex_jump_flag = 0; ex_jump_pc = 0;
    ex_reti = 0; ld_hazard = 0; int_req = 0; int_en = 0; inst_addr = 0;
    repeat (2) @(negedge clk);
    expectOut("reset", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(0);
    rst_n = 1'b1;

    // T2: taken branch
    applyStimulus(1,0,0,16'h0,0,0,0,0,16'h0);     expectOut("t2_c0", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,0,16'h0);     expectOut("t2_c1", HOLD_PC, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,0,16'h0);     expectOut("t2_c2", HOLD_PC, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,1,1,16'h0020,0,0,0,0,16'h0);  expectOut("t2_c3", HOLD_PC, 1, 16'h0020, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,0,16'h0);     expectOut("t2_c4", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);

    // T3: untaken branch, then a stray resolve in RUN
    applyStimulus(1,0,0,16'h0,0,0,0,0,16'h0);     expectOut("t3_c0", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,1,0,16'h0055,0,0,0,0,16'h0);  expectOut("t3_c1", HOLD_PC, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,0,16'h0);     expectOut("t3_c2", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,1,1,16'h0066,0,0,0,0,16'h0);  expectOut("stray_done", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);

    // T4: interrupt entry, request dropped during drain
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0013);  expectOut("t4_c0", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0013);  expectOut("t4_c1", HOLD_PC, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0013);  expectOut("t4_c2", HOLD_PC, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0013);  expectOut("t4_enter", HOLD_NONE, 1, 16'h0004, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0004);  expectOut("t4_ack", HOLD_NONE, 0, 16'h0, 1, 1, 16'h0013); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0005);  expectOut("t4_ack_once", HOLD_NONE, 0, 16'h0, 0, 1, 16'h0013); checkOutput(1);

    // T5: second request held off until RETI, then accepted
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0006);  expectOut("t5_nonest", HOLD_NONE, 0, 16'h0, 0, 1, 16'h0013); checkOutput(1);
    applyStimulus(1,0,0,16'h0,0,0,1,1,16'h0007);  expectOut("t5_c1", HOLD_NONE, 0, 16'h0, 0, 1, 16'h0013); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0008);  expectOut("t5_c2", HOLD_PC, 0, 16'h0, 0, 1, 16'h0013); checkOutput(1);
    applyStimulus(0,1,0,16'h0,1,0,1,1,16'h0008);  expectOut("t5_reti", HOLD_PC, 1, 16'h0013, 0, 1, 16'h0013); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0030);  expectOut("t5_run", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0013); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0030);  expectOut("t5_d1", HOLD_PC, 0, 16'h0, 0, 0, 16'h0013); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0030);  expectOut("t5_d2", HOLD_PC, 0, 16'h0, 0, 0, 16'h0013); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0030);  expectOut("t5_enter", HOLD_NONE, 1, 16'h0004, 0, 0, 16'h0013); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0004);  expectOut("t5_ack", HOLD_NONE, 0, 16'h0, 1, 1, 16'h0030); checkOutput(1);
    applyStimulus(1,0,0,16'h0,0,0,0,1,16'h0005);  expectOut("t5_r2a", HOLD_NONE, 0, 16'h0, 0, 1, 16'h0030); checkOutput(1);
    applyStimulus(0,1,0,16'h0,1,0,0,1,16'h0005);  expectOut("t5_r2b", HOLD_PC, 1, 16'h0030, 0, 1, 16'h0030); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0030);  expectOut("t5_r2c", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0030); checkOutput(1);

    // T6: branch beats a same-cycle interrupt
    applyStimulus(1,0,0,16'h0,0,0,1,1,16'h0040);  expectOut("t6_c0", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0030); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0040);  expectOut("t6_c1", HOLD_PC, 0, 16'h0, 0, 0, 16'h0030); checkOutput(1);
    applyStimulus(0,1,1,16'h0050,0,0,1,1,16'h0040); expectOut("t6_br", HOLD_PC, 1, 16'h0050, 0, 0, 16'h0030); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0044);  expectOut("t6_run", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0030); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0044);  expectOut("t6_d1", HOLD_PC, 0, 16'h0, 0, 0, 16'h0030); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0044);  expectOut("t6_d2", HOLD_PC, 0, 16'h0, 0, 0, 16'h0030); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0044);  expectOut("t6_enter", HOLD_NONE, 1, 16'h0004, 0, 0, 16'h0030); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0004);  expectOut("t6_ack", HOLD_NONE, 0, 16'h0, 1, 1, 16'h0044); checkOutput(1);
    applyStimulus(1,0,0,16'h0,0,0,0,1,16'h0005);  expectOut("t6_r_a", HOLD_NONE, 0, 16'h0, 0, 1, 16'h0044); checkOutput(1);
    applyStimulus(0,1,0,16'h0,1,0,0,1,16'h0005);  expectOut("t6_r_b", HOLD_PC, 1, 16'h0044, 0, 1, 16'h0044); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0044);  expectOut("t6_r_c", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);

    // Load-use hazards in RUN and BR_WAIT
    applyStimulus(0,0,0,16'h0,0,1,0,0,16'h0);     expectOut("ld_c0", HOLD_PPL, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,1,0,0,16'h0);     expectOut("ld_c1", HOLD_PPL, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,0,16'h0);     expectOut("ld_c2", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(1,0,0,16'h0,0,1,0,0,16'h0);     expectOut("ld_c3", HOLD_PPL, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(0,1,1,16'h0070,0,1,0,0,16'h0);  expectOut("ld_jump", HOLD_PPL, 1, 16'h0070, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,0,16'h0);     expectOut("ld_c5", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);

    // Hazard during drain freezes the counter
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0088);  expectOut("fz_c0", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,1,0,1,16'h0088);  expectOut("fz_c1", HOLD_PPL, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0088);  expectOut("fz_c2", HOLD_PC, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0088);  expectOut("fz_c3", HOLD_PC, 0, 16'h0, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0088);  expectOut("fz_enter", HOLD_NONE, 1, 16'h0004, 0, 0, 16'h0044); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0004);  expectOut("fz_ack", HOLD_NONE, 0, 16'h0, 1, 1, 16'h0088); checkOutput(1);
    applyStimulus(1,0,0,16'h0,0,0,0,1,16'h0005);  expectOut("fz_r_a", HOLD_NONE, 0, 16'h0, 0, 1, 16'h0088); checkOutput(1);
    applyStimulus(0,1,0,16'h0,1,0,0,1,16'h0005);  expectOut("fz_r_b", HOLD_PC, 1, 16'h0088, 0, 1, 16'h0088); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,1,16'h0088);  expectOut("fz_r_c", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0088); checkOutput(1);

    // T1: asynchronous reset in the middle of DRAIN
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0099);  expectOut("t1_c0", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0088); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0099);  expectOut("t1_drain", HOLD_PC, 0, 16'h0, 0, 0, 16'h0088); checkOutput(1);
    #2 rst_n = 1'b0;
    #1 expectOut("t1_async", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(0);
    applyStimulus(0,0,0,16'h0,0,0,1,1,16'h0099);  expectOut("t1_held", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,0,16'h0);
    rst_n = 1'b1;
    expectOut("t1_release", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);
    applyStimulus(0,0,0,16'h0,0,0,0,0,16'h0);     expectOut("t1_no_ack", HOLD_NONE, 0, 16'h0, 0, 0, 16'h0); checkOutput(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
